// File: rtl/cache_miss_handler.sv
// cache_miss_handler: miss-side sequencer for the 2-way LC-3b cache.
// On a miss it writes the LRU victim back to physical memory (only when it is
// valid and dirty), fetches the requested line, installs it into the victim
// way through the array write port, and then spends one settle cycle so the
// arrays and hit check can re-evaluate before the next request is taken.
module cache_miss_handler #(
   parameter int TAG_W  = 9,
   parameter int SET_W  = 3,
   parameter int OFF_W  = 4,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              miss_req,
   input  logic [15:0]       miss_addr,
   input  logic              lru_way,
   input  logic              victim_valid,
   input  logic              victim_dirty,
   input  logic [TAG_W-1:0]  victim_tag,
   input  logic [LINE_W-1:0] victim_line,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [15:0]       pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic              fill_we,
   output logic              fill_way,
   output logic [SET_W-1:0]  fill_set,
   output logic [TAG_W-1:0]  fill_tag,
   output logic [LINE_W-1:0] fill_line,
   output logic              busy,
   output logic              miss_done
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WRITEBACK = 3'd1,
      S_FETCH     = 3'd2,
      S_INSTALL   = 3'd3,
      S_SETTLE    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [SET_W-1:0]    set_q, set_d;
   logic                way_q, way_d;
   logic [TAG_W-1:0]    vtag_q, vtag_d;
   logic [LINE_W-1:0]   vline_q, vline_d;
   logic [LINE_W-1:0]   fill_line_q, fill_line_d;

   // Offset bits of the miss address are dropped: every memory access is line-aligned.
   logic unused_offset_bits;
   assign unused_offset_bits = ^miss_addr[OFF_W-1:0];

   // State and request-context registers; async reset abandons any transaction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tag_q       <= '0;
         set_q       <= '0;
         way_q       <= 1'b0;
         vtag_q      <= '0;
         vline_q     <= '0;
         fill_line_q <= '0;
      end else begin
         state_q     <= state_d;
         tag_q       <= tag_d;
         set_q       <= set_d;
         way_q       <= way_d;
         vtag_q      <= vtag_d;
         vline_q     <= vline_d;
         fill_line_q <= fill_line_d;
      end
   end

   // Next-state logic; request inputs are captured only on the IDLE accept.
   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      set_d       = set_q;
      way_d       = way_q;
      vtag_d      = vtag_q;
      vline_d     = vline_q;
      fill_line_d = fill_line_q;
      case (state_q)
         S_IDLE: begin
            if (miss_req) begin
               tag_d   = miss_addr[OFF_W+SET_W +: TAG_W];
               set_d   = miss_addr[OFF_W +: SET_W];
               way_d   = lru_way;
               vtag_d  = victim_tag;
               vline_d = victim_line;
               if (victim_valid && victim_dirty) begin
                  state_d = S_WRITEBACK;
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WRITEBACK: begin
            if (pmem_resp) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_FETCH: begin
            if (pmem_resp) begin
               fill_line_d = pmem_rdata;
               state_d     = S_INSTALL;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_INSTALL: state_d = S_SETTLE;
         S_SETTLE:  state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output decode from registered state only; nothing here looks at pmem_resp.
   always_comb begin
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = 16'h0000;
      pmem_wdata   = '0;
      fill_we      = 1'b0;
      fill_way     = 1'b0;
      fill_set     = '0;
      fill_tag     = '0;
      fill_line    = '0;
      miss_done    = 1'b0;
      busy         = (state_q != S_IDLE);
      case (state_q)
         S_WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {vtag_q, set_q, {OFF_W{1'b0}}};
            pmem_wdata   = vline_q;
         end
         S_FETCH: begin
            pmem_read    = 1'b1;
            pmem_address = {tag_q, set_q, {OFF_W{1'b0}}};
         end
         S_INSTALL: begin
            fill_we   = 1'b1;
            fill_way  = way_q;
            fill_set  = set_q;
            fill_tag  = tag_q;
            fill_line = fill_line_q;
            miss_done = 1'b1;
         end
         S_IDLE:   busy = 1'b0;
         S_SETTLE: busy = 1'b1;
         default:  busy = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_cache_miss_handler.sv
// tb_cache_miss_handler: scoreboard bench for cache_miss_handler.
// Expected installs are queued when a miss is driven and popped by a monitor
// whenever fill_we is seen; the main thread checks the pmem handshake inline.
module tb_cache_miss_handler;

   typedef struct packed {
      logic         way;
      logic [2:0]   set;
      logic [8:0]   tag;
      logic [127:0] line;
   } fill_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         miss_req;
   logic [15:0]  miss_addr;
   logic         lru_way;
   logic         victim_valid;
   logic         victim_dirty;
   logic [8:0]   victim_tag;
   logic [127:0] victim_line;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;
   logic         fill_we;
   logic         fill_way;
   logic [2:0]   fill_set;
   logic [8:0]   fill_tag;
   logic [127:0] fill_line;
   logic         busy;
   logic         miss_done;

   int    vectors = 0;
   int    miscompares = 0;
   fill_t exp_q[$];

   cache_miss_handler dut (
      .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
      .lru_way(lru_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
      .victim_tag(victim_tag), .victim_line(victim_line),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .fill_we(fill_we), .fill_way(fill_way), .fill_set(fill_set),
      .fill_tag(fill_tag), .fill_line(fill_line), .busy(busy), .miss_done(miss_done)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Install monitor: every fill_we must match the oldest outstanding miss.
   always @(negedge clk) begin
      if (!reset) begin
         check_val("rw_excl", {127'd0, pmem_read & pmem_write}, 128'd0);
         if (fill_we) begin
            if (exp_q.size() == 0) begin
               check_val("fill_unexpected", 128'd1, 128'd0);
            end else begin
               fill_t e;
               e = exp_q.pop_front();
               check_val("fill_way",  {127'd0, fill_way},  {127'd0, e.way});
               check_val("fill_set",  {125'd0, fill_set},  {125'd0, e.set});
               check_val("fill_tag",  {119'd0, fill_tag},  {119'd0, e.tag});
               check_val("fill_line", fill_line, e.line);
               check_val("miss_done_with_we", {127'd0, miss_done}, 128'd1);
            end
         end
      end
   end

   // Drive one miss from IDLE through SETTLE back to IDLE.
   task automatic do_miss(input logic [15:0] addr, input logic way, input logic valid,
                          input logic dirty, input logic [8:0] vtag, input logic [127:0] vline,
                          input logic [127:0] rdata, input int wb_wait, input int fetch_wait,
                          input logic churn);
      fill_t e;
      check_val("idle_before", {127'd0, busy}, 128'd0);
      miss_req     = 1'b1;
      miss_addr    = addr;
      lru_way      = way;
      victim_valid = valid;
      victim_dirty = dirty;
      victim_tag   = vtag;
      victim_line  = vline;
      e.way  = way;
      e.set  = addr[6:4];
      e.tag  = addr[15:7];
      e.line = rdata;
      exp_q.push_back(e);
      step();
      if (!churn) miss_req = 1'b0;
      check_val("busy_after_accept", {127'd0, busy}, 128'd1);
      if (valid && dirty) begin
         for (int i = 0; i <= wb_wait; i++) begin
            check_val("wb_write", {127'd0, pmem_write}, 128'd1);
            check_val("wb_read",  {127'd0, pmem_read},  128'd0);
            check_val("wb_addr",  {112'd0, pmem_address}, {112'd0, vtag, addr[6:4], 4'b0000});
            check_val("wb_data",  pmem_wdata, vline);
            if (i == wb_wait) pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
         end
      end
      for (int i = 0; i <= fetch_wait; i++) begin
         check_val("fetch_read",  {127'd0, pmem_read},  128'd1);
         check_val("fetch_write", {127'd0, pmem_write}, 128'd0);
         check_val("fetch_addr",  {112'd0, pmem_address}, {112'd0, addr[15:4], 4'b0000});
         if (churn) begin
            miss_addr  = ~addr;
            lru_way    = ~way;
            victim_tag = ~vtag;
         end
         if (i == fetch_wait) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rdata;
         end
         step();
         pmem_resp  = 1'b0;
         pmem_rdata = {4{$urandom()}};
      end
      check_val("install_we",   {127'd0, fill_we},   128'd1);
      check_val("install_done", {127'd0, miss_done}, 128'd1);
      check_val("install_read", {127'd0, pmem_read}, 128'd0);
      step();
      check_val("settle_busy", {127'd0, busy},    128'd1);
      check_val("settle_we",   {127'd0, fill_we}, 128'd0);
      check_val("settle_done", {127'd0, miss_done}, 128'd0);
      step();
      check_val("back_idle", {127'd0, busy}, 128'd0);
      miss_req = 1'b0;
   endtask

   // Main stimulus sequence.
   initial begin
      reset        = 1'b1;
      miss_req     = 1'b0;
      miss_addr    = 16'h0000;
      lru_way      = 1'b0;
      victim_valid = 1'b0;
      victim_dirty = 1'b0;
      victim_tag   = 9'h000;
      victim_line  = 128'd0;
      pmem_rdata   = 128'd0;
      pmem_resp    = 1'b0;
      repeat (2) step();
      check_val("rst_busy",  {127'd0, busy}, 128'd0);
      check_val("rst_rw",    {126'd0, pmem_read, pmem_write}, 128'd0);
      check_val("rst_addr",  {112'd0, pmem_address}, 128'd0);
      check_val("rst_fill",  {114'd0, fill_we, fill_way, fill_set, fill_tag}, 128'd0);
      check_val("rst_line",  fill_line, 128'd0);
      reset = 1'b0;
      step();

      // Stray response while idle must be ignored.
      pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
      check_val("stray_idle_busy", {127'd0, busy}, 128'd0);
      step();
      check_val("stray_idle_busy2", {127'd0, busy}, 128'd0);

      // Clean miss, then dirty miss, then invalid-but-dirty victim.
      do_miss(16'h1234, 1'b1, 1'b1, 1'b0, 9'h055, {16{8'h3C}}, {16{8'hA5}}, 0, 2, 1'b0);
      do_miss(16'h0450, 1'b0, 1'b1, 1'b1, 9'h1FF,
              128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF, {4{32'h600D_F00D}}, 3, 1, 1'b0);
      do_miss(16'h7A9C, 1'b1, 1'b0, 1'b1, 9'h0AA, {4{32'hBADC_0FFE}}, {4{32'h1357_9BDF}}, 0, 0, 1'b0);
      // Back-to-back with input churn and miss_req held through SETTLE.
      do_miss(16'hC3F0, 1'b0, 1'b1, 1'b1, 9'h101, {4{32'h0F0F_0F0F}}, {4{32'h2468_ACE0}}, 1, 2, 1'b1);
      step();
      check_val("after_churn_idle", {127'd0, busy}, 128'd0);

      // Reset in the middle of a writeback abandons the request.
      miss_req     = 1'b1;
      miss_addr    = 16'h0450;
      lru_way      = 1'b1;
      victim_valid = 1'b1;
      victim_dirty = 1'b1;
      victim_tag   = 9'h1FF;
      victim_line  = {4{32'hCAFE_D00D}};
      step();
      miss_req = 1'b0;
      check_val("mid_wb_write", {127'd0, pmem_write}, 128'd1);
      step();
      #1 reset = 1'b1;
      #1;
      check_val("rst_mid_busy",  {127'd0, busy}, 128'd0);
      check_val("rst_mid_write", {127'd0, pmem_write}, 128'd0);
      check_val("rst_mid_addr",  {112'd0, pmem_address}, 128'd0);
      check_val("rst_mid_wdata", pmem_wdata, 128'd0);
      check_val("rst_mid_we",    {127'd0, fill_we}, 128'd0);
      step();
      reset = 1'b0;
      pmem_resp = 1'b1;
      step();
      pmem_resp = 1'b0;
      check_val("post_rst_busy", {127'd0, busy}, 128'd0);
      check_val("post_rst_read", {127'd0, pmem_read}, 128'd0);
      step();
      check_val("post_rst_we",   {127'd0, fill_we}, 128'd0);

      // One more clean miss proves the block recovered.
      do_miss(16'hFFFF, 1'b1, 1'b1, 1'b0, 9'h000, 128'd0, {4{32'h8765_4321}}, 0, 0, 1'b0);
      step();
      check_val("sb_empty", exp_q.size(), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cache_miss_handler.md
Name: cache_miss_handler

Overview:
- Miss-side companion to the 2-way cache hit-check logic in the LC-3b cache.
- When a lookup misses, this block takes the LRU victim way and writes that line back to physical memory if it is dirty.
- It then fetches the requested line and installs it into the victim way through the array write port.
- It sits between the cache control path, the data/tag/valid/dirty arrays, and the physical-memory interface.

Parameters:
TAG_W, 9, tag width (address bits [15:7])
SET_W, 3, set index width (address bits [6:4])
OFF_W, 4, byte offset width (address bits [3:0]); TAG_W+SET_W+OFF_W must equal 16
LINE_W, 128, cache line width in bits

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
miss_req  in  1  level; cache control reports a miss for miss_addr
miss_addr  in  16  CPU address (lc3b_word) that missed
lru_way  in  1  LRU way of the addressed set, valid while miss_req is high
victim_valid  in  1  valid bit of lru_way in the addressed set
victim_dirty  in  1  dirty bit of lru_way in the addressed set
victim_tag  in  TAG_W  tag of lru_way in the addressed set
victim_line  in  LINE_W  data of lru_way in the addressed set
pmem_read  out  1  physical-memory read request
pmem_write  out  1  physical-memory write request
pmem_address  out  16  line-aligned physical address
pmem_wdata  out  LINE_W  writeback data
pmem_rdata  in  LINE_W  fetched line
pmem_resp  in  1  one-cycle completion from physical memory
fill_we  out  1  array write strobe: data, tag, valid=1, dirty=0
fill_way  out  1  way being written
fill_set  out  SET_W  set being written
fill_tag  out  TAG_W  tag being written
fill_line  out  LINE_W  line being written
busy  out  1  high in every state except IDLE
miss_done  out  1  one-cycle pulse when the line has been installed

Behaviour:
- States: IDLE, WRITEBACK, FETCH, INSTALL, SETTLE.
- Reset (async, any state): state returns to IDLE. Every output and every internal register (latched address, way, victim tag, victim line, fill line) clears to 0.
- IDLE, miss_req=1:
  - Latch tag=miss_addr[15:7], set=miss_addr[6:4], way=lru_way, victim_tag, victim_line.
  - Next state is WRITEBACK if victim_valid && victim_dirty, otherwise FETCH.
  - All other inputs are ignored in IDLE, including pmem_resp.
- WRITEBACK:
  - pmem_write=1, pmem_address={latched victim_tag, set, 4'b0}, pmem_wdata=latched victim_line, all held stable.
  - On pmem_resp=1, go to FETCH. pmem_write drops in the same cycle as the state change.
- FETCH:
  - pmem_read=1, pmem_address={tag, set, 4'b0}.
  - On pmem_resp=1, capture pmem_rdata into the fill register and go to INSTALL.
- INSTALL (exactly 1 cycle):
  - fill_we=1 with fill_way=way, fill_set=set, fill_tag=tag, fill_line=captured data.
  - miss_done=1 in the same cycle.
  - Go to SETTLE.
- SETTLE (exactly 1 cycle): no requests are accepted, so the arrays and hit check can re-evaluate. Then go to IDLE.
- Physical-memory request rules:
  - pmem_read and pmem_write are never high together.
  - Each is high only in its own state, and only until its pmem_resp.
  - pmem_resp outside WRITEBACK/FETCH is ignored.
- Request latching: miss_req, miss_addr, lru_way and the victim_* inputs are sampled only on IDLE→accept. Changes while busy have no effect.
- Timing:
  - pmem outputs and fill_* are registered-state decodes; none depends combinationally on pmem_resp.
  - Minimum latency, miss_req to miss_done: clean victim = 3 cycles (accept, FETCH with immediate resp, INSTALL). Dirty victim adds 1 plus the writeback wait.
- Reset mid-transaction: the request is abandoned and no fill_we is issued. An outstanding pmem_resp arriving after reset is ignored.
- Addresses are always line-aligned; offset bits are forced to 0.

Test Plan:
- Clean miss: reset, then miss_req with miss_addr=16'h1234, lru_way=1, victim_valid=1, victim_dirty=0; pmem_resp 2 cycles after pmem_read, pmem_rdata=128'hA5…A5 -> pmem_read with pmem_address=16'h1230, no pmem_write, one fill_we with way=1, set=3, tag=9'h024, line=A5…A5, miss_done coincident, then 1 SETTLE cycle.
- Dirty miss: miss_addr=16'h0450, lru_way=0, victim_dirty=1, victim_tag=9'h1FF, victim_line=128'hDEAD…BEEF -> pmem_write at 16'hFFD0 with that data until resp, then pmem_read at 16'h0450, then install to way 0, set 5.
- Invalid victim: victim_valid=0, victim_dirty=1 -> no writeback; FETCH is entered directly.
- Input churn while busy: change miss_addr, lru_way and victim_tag during FETCH -> install still uses the values latched at accept; miss_req held high through SETTLE causes no re-accept until IDLE.
- Reset mid-WRITEBACK: assert reset while pmem_write=1 -> all outputs 0 immediately; a later stray pmem_resp produces no transition and no fill_we.
- Stray pmem_resp in IDLE, and back-to-back misses -> stray resp ignored; second miss accepted on the first IDLE cycle after SETTLE; busy low only in IDLE.
